// File: rtl/mux8x1_scanner_if.sv
// mux8x1_scanner_if: scan request/response and mux-side signals of the scanner
interface mux8x1_scanner_if;
  logic       start;
  logic [7:0] data_in;
  logic       msb_first;
  logic       mux_dout;
  logic [7:0] mux_din;
  logic [2:0] mux_sel;
  logic       busy;
  logic       bit_valid;
  logic       bit_out;
  logic       done;
  logic [7:0] rx_byte;
  logic       mismatch;
  modport master(
    output start, data_in, msb_first, mux_dout,
    input  mux_din, mux_sel, busy, bit_valid, bit_out, done, rx_byte, mismatch
  );
  modport slave(
    input  start, data_in, msb_first, mux_dout,
    output mux_din, mux_sel, busy, bit_valid, bit_out, done, rx_byte, mismatch
  );
endinterface

// File: rtl/mux8x1_scanner.sv
// mux8x1_scanner: steps an 8:1 mux select over a latched byte and rebuilds it from the mux output
module mux8x1_scanner #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input logic             clk,
  input logic             rst_n,
  mux8x1_scanner_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t     state_q, state_d;
  logic [7:0] mux_din_q, mux_din_d, hold_q, hold_d, shadow_q, shadow_d, rx_byte_q, rx_byte_d, full;
  logic [2:0] mux_sel_q, mux_sel_d, cnt_q, cnt_d;
  logic       msb_q, msb_d, busy_q, busy_d, bit_valid_q, bit_valid_d, bit_out_q, bit_out_d;
  logic       done_q, done_d, mismatch_q, mismatch_d, take, smp, last;
  always_comb begin
    take = state_q == IDLE && bus.start;
    smp = state_q == SCAN && hold_q == 8'(HOLD_CYCLES - 1);
    last = smp && cnt_q == 3'd7;
    full = shadow_q;
    full[mux_sel_q] = bus.mux_dout;
    state_d = take ? SCAN : last ? DONE : state_q == DONE ? IDLE : state_q;
    mux_din_d = take ? bus.data_in : mux_din_q;
    msb_d = take ? bus.msb_first : msb_q;
    mux_sel_d = take ? (bus.msb_first ? 3'd7 : 3'd0)
              : (last || state_q != SCAN) ? 3'd0
              : !smp ? mux_sel_q
              : msb_q ? mux_sel_q - 3'd1 : mux_sel_q + 3'd1;
    hold_d = (state_q == SCAN && !smp) ? hold_q + 8'd1 : 8'd0;
    cnt_d = state_q != SCAN ? 3'd0 : smp ? cnt_q + 3'd1 : cnt_q;
    shadow_d = smp ? full : shadow_q;
    rx_byte_d = last ? full : rx_byte_q;
    mismatch_d = last ? (full != mux_din_q) : mismatch_q;
    bit_valid_d = smp;
    bit_out_d = smp ? bus.mux_dout : bit_out_q;
    done_d = last;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mux_din_q <= 8'd0;
      msb_q <= 1'b0;
      mux_sel_q <= 3'd0;
      hold_q <= 8'd0;
      cnt_q <= 3'd0;
      shadow_q <= 8'd0;
      rx_byte_q <= 8'd0;
      mismatch_q <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_out_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mux_din_q <= mux_din_d;
      msb_q <= msb_d;
      mux_sel_q <= mux_sel_d;
      hold_q <= hold_d;
      cnt_q <= cnt_d;
      shadow_q <= shadow_d;
      rx_byte_q <= rx_byte_d;
      mismatch_q <= mismatch_d;
      bit_valid_q <= bit_valid_d;
      bit_out_q <= bit_out_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end
  assign bus.mux_din = mux_din_q;
  assign bus.mux_sel = mux_sel_q;
  assign bus.busy = busy_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.bit_out = bit_out_q;
  assign bus.done = done_q;
  assign bus.rx_byte = rx_byte_q;
  assign bus.mismatch = mismatch_q;
endmodule

// File: doc/mux8x1_scanner.md
# mux8x1_scanner

Sequencing stage that sits directly upstream of the `mux8x1` 8:1 bit selector and drives its `din` and `sel` inputs. On a start request it latches a byte and steps `sel` through all eight positions, either LSB-first or MSB-first. It samples the mux's `dout` on each step to rebuild the byte and reports per-bit strobes, the reassembled byte and a loopback mismatch flag. Used as a serializer front-end and as a built-in self-check of the mux path.

## Interface
- `HOLD_CYCLES`, default 1: clock cycles each `sel` value is held before `dout` is sampled. Legal values are 1 to 255.
- `clk`  input  1  sole clock, rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `start`  input  1  request a scan; sampled only in IDLE.
- `data_in`  input  8  byte to scan; latched on the accepting edge.
- `msb_first`  input  1  scan order; latched with `data_in`. 0 = sel 0→7, 1 = sel 7→0.
- `mux_dout`  input  1  the mux output, combinational from `mux_din`/`mux_sel`.
- `mux_din`  output  8  byte presented to the mux `din`.
- `mux_sel`  output  3  select presented to the mux `sel`.
- `busy`  output  1  high in SCAN and DONE.
- `bit_valid`  output  1  one-cycle strobe per sampled bit.
- `bit_out`  output  1  bit sampled for the current `bit_valid`.
- `done`  output  1  one-cycle strobe at end of scan.
- `rx_byte`  output  8  reassembled byte; holds until the next `done`.
- `mismatch`  output  1  `rx_byte != mux_din`; updated with `done` and held.

## Operation
- States: IDLE → SCAN → DONE → IDLE. All outputs are registered.
- **IDLE:**
  - `busy` = 0 and `mux_sel` = 0.
  - When `start` = 1 at an edge: latch `mux_din` ← `data_in` and the order bit.
  - Set `mux_sel` ← 7 if `msb_first`, else 0. Clear the hold counter, clear the bit counter, enter SCAN.
- **SCAN:**
  - The hold counter increments each cycle.
  - At the edge where hold counter = `HOLD_CYCLES`-1 (the sampling edge):
    - Write `rx_shadow[mux_sel]` ← `mux_dout`.
    - Register `bit_out` ← `mux_dout` and `bit_valid` ← 1.
    - Step `mux_sel` by ±1 per the order, clear the hold counter, increment the bit counter.
  - The bit index is always `mux_sel`, so a correct mux returns `rx_byte == mux_din` in either order.
- **Leaving SCAN:**
  - On the 8th sampling edge, enter DONE instead of stepping.
  - Register `rx_byte` ← the completed shadow, including the 8th bit.
  - Register `mismatch` ← (completed byte != `mux_din`), and `done` ← 1.
  - Force `mux_sel` ← 0.
- **DONE:** lasts one cycle, then returns to IDLE. `start` is ignored.
- **`start` while busy** (SCAN or DONE) is ignored, not queued. `data_in` and `msb_first` changes while busy have no effect.
- **Held values:** `mux_din` holds the last latched byte after the scan. `rx_byte` and `mismatch` hold until the next `done`.
- **Reset:** `rst_n` low at any time, including mid-scan, immediately forces IDLE. The scan in progress is abandoned with no `done`. Reset values:
  - `mux_din` = 0, `mux_sel` = 0, `rx_byte` = 0.
  - `busy` = 0, `bit_valid` = 0, `bit_out` = 0, `done` = 0, `mismatch` = 0.
  - Hold and bit counters = 0.

## Timing
- Edge E0 accepts `start`. `busy` and the first `mux_sel` are valid from E0.
- Sampling edges are E0 + k·`HOLD_CYCLES`, for k = 1..8.
- `bit_valid` is high for exactly the cycle following each sampling edge, giving 8 pulses per scan.
- `done` is high in the cycle after E0 + 8·`HOLD_CYCLES`, coincident with the 8th `bit_valid`. `rx_byte` and `mismatch` are valid in that same cycle.
- With `HOLD_CYCLES` = 1, the 8 `bit_valid` pulses occupy 8 consecutive cycles.
- `busy` falls at E0 + 8·`HOLD_CYCLES` + 1.
- The earliest next accepted `start` is at edge E0 + 8·`HOLD_CYCLES` + 2.
- `mux_dout` must settle within `HOLD_CYCLES` clock periods of a `mux_sel`/`mux_din` change.

## Test plan
- **Reset values:** assert `rst_n` = 0 with random inputs → all outputs are 0. Release, then hold `start` = 0 for 5 cycles → outputs stay 0.
- **LSB-first, real `mux8x1`:** `HOLD_CYCLES` = 1, `data_in` = 8'hA5, `msb_first` = 0, one-cycle `start` →
  - `mux_sel` steps 0,1,...,7, and `bit_out` reads 1,0,1,0,0,1,0,1.
  - `done` is high in the 9th cycle after the accepting edge, with `rx_byte` = 8'hA5 and `mismatch` = 0.
- **MSB-first, `HOLD_CYCLES` = 3:** `data_in` = 8'h3C, `msb_first` = 1 →
  - `mux_sel` goes 7 down to 0, each value held 3 cycles.
  - `bit_out` reads 0,0,1,1,1,1,0,0.
  - `done` is high in the 25th cycle after the accepting edge, with `rx_byte` = 8'h3C.
- **Fault injection:** tie `mux_dout` = 0 and scan 8'hFF → `rx_byte` = 8'h00 and `mismatch` = 1. The next good scan of 8'h00 clears `mismatch` to 0.
- **Start while busy:**
  - Pulse `start` with 8'h0F during the 4th bit of a scan of 8'hF0 → the scan completes with `rx_byte` = 8'hF0 and only one `done` occurs.
  - `start` held high continuously → new scans are accepted every 10 cycles.
- **Reset mid-scan:** drop `rst_n` for 1 cycle after 3 `bit_valid` pulses →
  - No `done` is issued and all outputs are 0.
  - A fresh scan of 8'h81 then completes with `rx_byte` = 8'h81.
